sfx_sequencer: RTL

Sound-effect sequencer and arbiter that shares the single square-wave tone generator between several requesters (scene logic, beat triggers, and similar). It grants one requester at a time by fixed priority. It walks that requester's note list in the synchronous SFX ROM and drives the generator's 8-bit note code for the programmed duration of each note. It sits between the scene/control logic and the tone generator, and replaces free-running ROM addressing with event-driven playback.

---
 rtl/sfx_sequencer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/sfx_sequencer.sv
// Fixed-priority sound-effect sequencer: grants one requester and walks its note list in the SFX ROM.
// Optional build macro SFX_PREEMPT_EN lets a higher-priority request interrupt a note in PLAY.
module sfx_sequencer #(
  parameter int NUM_REQ  = 4,
  parameter int TICK_DIV = 4194304
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] req_addr,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   done,
  output logic                 busy,
  output logic [7:0]           rom_addr,
  input  logic [7:0]           rom_data,
  output logic [7:0]           note_out
);

  localparam int DUR_W = $clog2(8 * TICK_DIV);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_DECODE = 2'd2;
  localparam logic [1:0] ST_PLAY   = 2'd3;

  localparam logic [7:0] END_MARK = 8'hFF;

  logic [1:0]         state;
  logic [DUR_W-1:0]   dur_cnt;
  logic [NUM_REQ-1:0] req_pick;
  logic [7:0]         pick_addr;

  // Isolate the lowest set bit, i.e. the highest-priority requester.
  function automatic logic [NUM_REQ-1:0] lowest_onehot(input logic [NUM_REQ-1:0] x);
    return x & (~x + NUM_REQ'(1));
  endfunction

  function automatic logic [7:0] addr_of(input logic [NUM_REQ-1:0]   oh,
                                         input logic [NUM_REQ*8-1:0] addrs);
    logic [7:0] a;
    a = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) a = a | addrs[8*i +: 8];
    end
    return a;
  endfunction

  // Length code n selects 2^n units; the counter runs down to zero, hence the -1.
  function automatic logic [DUR_W-1:0] dur_load(input logic [1:0] len);
    return DUR_W'((TICK_DIV << len) - 1);
  endfunction

  always_comb begin
    req_pick  = lowest_onehot(req);
    pick_addr = addr_of(req_pick, req_addr);
  end

`ifdef SFX_PREEMPT_EN
  logic [NUM_REQ-1:0] higher_mask;
  logic [NUM_REQ-1:0] preempt_pick;
  logic [7:0]         preempt_addr;

  // Bits strictly below the granted one are the only ones allowed to interrupt.
  always_comb begin
    higher_mask  = grant - NUM_REQ'(1);
    preempt_pick = lowest_onehot(req & higher_mask);
    preempt_addr = addr_of(preempt_pick, req_addr);
  end
`endif

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      grant    <= '0;
      done     <= '0;
      rom_addr <= '0;
      note_out <= '0;
      dur_cnt  <= '0;
    end else begin
      done <= '0;
      case (state)
        ST_IDLE: begin
          if (|req) begin
            grant    <= req_pick;
            rom_addr <= pick_addr;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          state <= ST_DECODE;
        end
        ST_DECODE: begin
          if (rom_data == END_MARK) begin
            done     <= grant;
            grant    <= '0;
            note_out <= '0;
            state    <= ST_IDLE;
          end else begin
            note_out <= {2'b00, rom_data[5:0]};
            dur_cnt  <= dur_load(rom_data[7:6]);
            rom_addr <= rom_addr + 8'd1;
            state    <= ST_PLAY;
          end
        end
        ST_PLAY: begin
`ifdef SFX_PREEMPT_EN
          if (|preempt_pick) begin
            done     <= grant;
            note_out <= '0;
            grant    <= preempt_pick;
            rom_addr <= preempt_addr;
            dur_cnt  <= '0;
            state    <= ST_WAIT;
          end else
`endif
          // note_out is left untouched so it carries through the next fetch.
          if (dur_cnt == '0) begin
            state <= ST_WAIT;
          end else begin
            dur_cnt <= dur_cnt - DUR_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
